bin_to_bcd_seq: RTL and testbench

//   Parametrised sequential binary-to-BCD converter (double-dabble, one bit per clk) for the

---
 rtl/bin_to_bcd_seq.sv | 194 +++++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// rtl/bin_to_bcd_seq.sv - sequential double-dabble binary to BCD/ASCII converter
//
// Purpose: converts one BIN_W-bit word per transaction into DIGITS BCD digits,
// one input bit per clock. Optional two's-complement input (SIGNED), leading-zero
// blanking (BLANK_LZ) and an ASCII rendering for the text/glyph path.
//
// Ports:
//   clk        system clock
//   rst        synchronous reset, active-high
//   in_valid   input word offered
//   in_ready   converter idle and able to accept
//   in_bin     value to convert
//   out_valid  result available, held until accepted
//   out_ready  consumer accepts result
//   out_bcd    BCD digits, [3:0] = units
//   out_neg    input was negative (always 0 when SIGNED=0)
//   out_ndig   significant digit count (1..DIGITS)
//   out_ascii  characters, [7:0] = units character

module bin_to_bcd_seq #(
  parameter int BIN_W    = 16,
  parameter int DIGITS   = 5,
  parameter bit SIGNED   = 1'b0,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIN_W-1:0]            in_bin,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [4*DIGITS-1:0]         out_bcd,
  output logic                        out_neg,
  output logic [$clog2(DIGITS+1)-1:0] out_ndig,
  output logic [8*DIGITS-1:0]         out_ascii
);

  localparam int CNT_W  = $clog2(BIN_W + 1);
  localparam int NDIG_W = $clog2(DIGITS + 1);

  // Largest magnitude must fit: unsigned needs 10**DIGITS > 2**BIN_W-1,
  // signed reserves the top digit for the sign and needs 10**(DIGITS-1) > 2**(BIN_W-1).
  function automatic bit sizing_ok();
    longint unsigned limit;
    longint unsigned pow10;
    int              need;
    limit = SIGNED ? (64'd1 << (BIN_W - 1)) : ((64'd1 << BIN_W) - 64'd1);
    need  = SIGNED ? DIGITS - 1 : DIGITS;
    pow10 = 64'd1;
    for (int i = 0; i < need; i++) begin
      if (pow10 <= limit) pow10 = pow10 * 64'd10;
    end
    return pow10 > limit;
  endfunction

  localparam bit SIZE_OK = sizing_ok();

  generate
    if (!SIZE_OK) begin : g_size_err
      $error("bin_to_bcd_seq: DIGITS too small for BIN_W/SIGNED");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_FMT   = 2'd2,
    S_HOLD  = 2'd3
  } state_t;

  state_t                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  logic [BIN_W-1:0]      mag_q,       mag_d;
  logic [4*DIGITS-1:0]   dig_q,       dig_d;
  logic                  neg_q,       neg_d;
  logic [4*DIGITS-1:0]   out_bcd_q,   out_bcd_d;
  logic                  out_neg_q,   out_neg_d;
  logic [NDIG_W-1:0]     out_ndig_q,  out_ndig_d;
  logic [8*DIGITS-1:0]   out_ascii_q, out_ascii_d;

  logic                  in_neg;
  logic [BIN_W-1:0]      in_mag;
  logic [4*DIGITS-1:0]   dig_adj;
  logic [NDIG_W-1:0]     fmt_ndig;
  logic [8*DIGITS-1:0]   fmt_ascii;

  assign in_ready  = (state_q == S_IDLE) && !rst;
  assign out_valid = (state_q == S_HOLD);
  assign out_bcd   = out_bcd_q;
  assign out_neg   = out_neg_q;
  assign out_ndig  = out_ndig_q;
  assign out_ascii = out_ascii_q;

  // Magnitude as BIN_W-bit unsigned: negating the most negative value wraps
  // back to itself, which read unsigned is exactly 2**(BIN_W-1).
  assign in_neg = SIGNED && in_bin[BIN_W-1];
  assign in_mag = in_neg ? (~in_bin + 1'b1) : in_bin;

  // Double-dabble correction applied before every shift.
  always_comb begin : p_dabble
    dig_adj = dig_q;
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_q[4*d +: 4] >= 4'd5) dig_adj[4*d +: 4] = dig_q[4*d +: 4] + 4'd3;
    end
  end

  always_comb begin : p_fmt
    fmt_ndig = NDIG_W'(1);
    for (int d = 0; d < DIGITS; d++) begin
      if (dig_q[4*d +: 4] != 4'd0) fmt_ndig = NDIG_W'(d + 1);
    end
    fmt_ascii = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (BLANK_LZ && (d >= int'(fmt_ndig))) fmt_ascii[8*d +: 8] = 8'h20;
      else                                    fmt_ascii[8*d +: 8] = {4'h3, dig_q[4*d +: 4]};
    end
    // Sign goes just left of the number when blanking, else in the top digit,
    // which the sizing rule guarantees is a zero for signed configurations.
    if (neg_q) begin
      if (BLANK_LZ) begin
        for (int d = 0; d < DIGITS; d++) begin
          if (d == int'(fmt_ndig)) fmt_ascii[8*d +: 8] = 8'h2D;
        end
      end else begin
        fmt_ascii[8*(DIGITS-1) +: 8] = 8'h2D;
      end
    end
  end

  always_comb begin : p_next
    state_d     = state_q;
    cnt_d       = cnt_q;
    mag_d       = mag_q;
    dig_d       = dig_q;
    neg_d       = neg_q;
    out_bcd_d   = out_bcd_q;
    out_neg_d   = out_neg_q;
    out_ndig_d  = out_ndig_q;
    out_ascii_d = out_ascii_q;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready) begin
          mag_d   = in_mag;
          neg_d   = in_neg;
          dig_d   = '0;
          cnt_d   = CNT_W'(BIN_W);
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        {dig_d, mag_d} = {dig_adj, mag_q} << 1;
        cnt_d          = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = S_FMT;
      end
      S_FMT: begin
        out_bcd_d   = dig_q;
        out_neg_d   = neg_q;
        out_ndig_d  = fmt_ndig;
        out_ascii_d = fmt_ascii;
        state_d     = S_HOLD;
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      mag_q       <= '0;
      dig_q       <= '0;
      neg_q       <= 1'b0;
      out_bcd_q   <= '0;
      out_neg_q   <= 1'b0;
      out_ndig_q  <= '0;
      out_ascii_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mag_q       <= mag_d;
      dig_q       <= dig_d;
      neg_q       <= neg_d;
      out_bcd_q   <= out_bcd_d;
      out_neg_q   <= out_neg_d;
      out_ndig_q  <= out_ndig_d;
      out_ascii_q <= out_ascii_d;
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb/tb_bin_to_bcd_seq.sv - bench for bin_to_bcd_seq in three configurations
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] in_bin = 16'd0;

  always #5 clk = ~clk;

  // a: unsigned, blanking; b: unsigned, no blanking; c: signed, 6 digits, blanking
  logic        a_ready, a_valid, a_neg;
  logic [19:0] a_bcd;
  logic [2:0]  a_ndig;
  logic [39:0] a_ascii;
  logic        b_ready, b_valid, b_neg;
  logic [19:0] b_bcd;
  logic [2:0]  b_ndig;
  logic [39:0] b_ascii;
  logic        c_ready, c_valid, c_neg;
  logic [23:0] c_bcd;
  logic [2:0]  c_ndig;
  logic [47:0] c_ascii;

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0), .BLANK_LZ(1'b1)) u_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(a_ready), .in_bin(in_bin),
    .out_valid(a_valid), .out_ready(out_ready), .out_bcd(a_bcd), .out_neg(a_neg),
    .out_ndig(a_ndig), .out_ascii(a_ascii));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(5), .SIGNED(1'b0), .BLANK_LZ(1'b0)) u_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(b_ready), .in_bin(in_bin),
    .out_valid(b_valid), .out_ready(out_ready), .out_bcd(b_bcd), .out_neg(b_neg),
    .out_ndig(b_ndig), .out_ascii(b_ascii));

  bin_to_bcd_seq #(.BIN_W(16), .DIGITS(6), .SIGNED(1'b1), .BLANK_LZ(1'b1)) u_c (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(c_ready), .in_bin(in_bin),
    .out_valid(c_valid), .out_ready(out_ready), .out_bcd(c_bcd), .out_neg(c_neg),
    .out_ndig(c_ndig), .out_ascii(c_ascii));

  typedef struct packed {
    logic [23:0] bcd;
    logic        neg;
    logic [2:0]  ndig;
    logic [47:0] ascii;
  } exp_t;

  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   ready_mode = 0;
  int   cfg_nd[3] = '{5, 5, 6};
  bit   cfg_sg[3] = '{1'b0, 1'b0, 1'b1};
  bit   cfg_bl[3] = '{1'b1, 1'b0, 1'b1};
  exp_t act[3];
  logic act_v[3];
  logic act_r[3];

  assign act[0] = {4'h0, a_bcd, a_neg, a_ndig, 8'h00, a_ascii};
  assign act[1] = {4'h0, b_bcd, b_neg, b_ndig, 8'h00, b_ascii};
  assign act[2] = {c_bcd, c_neg, c_ndig, c_ascii};
  assign act_v[0] = a_valid;
  assign act_v[1] = b_valid;
  assign act_v[2] = c_valid;
  assign act_r[0] = a_ready;
  assign act_r[1] = b_ready;
  assign act_r[2] = c_ready;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, got, want);
    end
  endtask

  // Decimal rendering from plain integer arithmetic.
  function automatic exp_t model(input logic [15:0] v, input int nd, input bit sgn, input bit blank);
    exp_t e;
    int   mag, t, n, pos;
    e     = '0;
    e.neg = sgn && v[15];
    mag   = e.neg ? 65536 - int'(v) : int'(v);
    n = 0;
    t = mag;
    while (t > 0) begin
      n++;
      t = t / 10;
    end
    e.ndig = 3'((n == 0) ? 1 : n);
    t = mag;
    for (int p = 0; p < nd; p++) begin
      e.bcd[4*p +: 4]   = 4'(t % 10);
      e.ascii[8*p +: 8] = (blank && (p >= int'(e.ndig))) ? 8'h20 : 8'h30 + 8'(t % 10);
      t = t / 10;
    end
    if (e.neg) begin
      pos = blank ? int'(e.ndig) : nd - 1;
      e.ascii[8*pos +: 8] = 8'h2D;
    end
    return e;
  endfunction

  // Transaction-level reference: idle -> busy for 18 cycles -> hold until accepted.
  exp_t        cur[3] = '{'0, '0, '0};
  int          m_st = 0;
  int          m_start = 0;
  logic [15:0] m_val = 16'd0;

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("valid%0d", i), 64'(act_v[i]), 64'(m_st == 2));
      chk($sformatf("in_ready%0d", i), 64'(act_r[i]), 64'((m_st == 0) && !rst));
      chk($sformatf("bcd%0d", i), 64'(act[i].bcd), 64'(cur[i].bcd));
      chk($sformatf("neg%0d", i), 64'(act[i].neg), 64'(cur[i].neg));
      chk($sformatf("ndig%0d", i), 64'(act[i].ndig), 64'(cur[i].ndig));
      chk($sformatf("ascii%0d", i), 64'(act[i].ascii), 64'(cur[i].ascii));
    end
    if (rst) begin
      m_st = 0;
      for (int i = 0; i < 3; i++) cur[i] = '0;
    end else if (m_st == 0) begin
      if (in_valid) begin
        m_st    = 1;
        m_start = cyc;
        m_val   = in_bin;
      end
    end else if (m_st == 1) begin
      if (cyc + 1 == m_start + 18) begin
        m_st = 2;
        for (int i = 0; i < 3; i++) cur[i] = model(m_val, cfg_nd[i], cfg_sg[i], cfg_bl[i]);
      end
    end else begin
      if (out_ready) m_st = 0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'b0;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] v, output int hs);
    bit done;
    done     = 1'b0;
    hs       = -1;
    in_valid = 1'b1;
    in_bin   = v;
    for (int n = 0; n < 200 && !done; n++) begin
      @(negedge clk);
      if (a_ready) begin
        done = 1'b1;
        hs   = cyc;
      end
    end
    chk("send_timeout", 64'(done), 64'd1);
    tick();
    in_valid = 1'b0;
    in_bin   = 16'($urandom);
  endtask

  task automatic wait_valid(input int hs, output int lat);
    bit done;
    done = 1'b0;
    lat  = -1;
    for (int n = 0; n < 60 && !done; n++) begin
      @(negedge clk);
      if (a_valid) begin
        done = 1'b1;
        lat  = cyc - hs;
      end
    end
    chk("valid_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    exp_t        e;
    int          hs, lat, hs_prev;
    logic [15:0] v;
    logic [15:0] b2b[3];
    b2b[0] = 16'd1;
    b2b[1] = 16'd9999;
    b2b[2] = 16'd10000;

    // Pin the reference model to hand-computed values.
    e = model(16'hFFFF, 5, 1'b0, 1'b1);
    chk("pin_65535_bcd", 64'(e.bcd), 64'h65535);
    chk("pin_65535_ndig", 64'(e.ndig), 64'd5);
    chk("pin_65535_ascii", 64'(e.ascii), 64'("65535"));
    e = model(16'd0, 5, 1'b0, 1'b1);
    chk("pin_0_blank", 64'(e.ascii), 64'("    0"));
    chk("pin_0_ndig", 64'(e.ndig), 64'd1);
    e = model(16'd0, 5, 1'b0, 1'b0);
    chk("pin_0_noblank", 64'(e.ascii), 64'("00000"));
    e = model(16'h8000, 6, 1'b1, 1'b1);
    chk("pin_8000_bcd", 64'(e.bcd), 64'h032768);
    chk("pin_8000_ascii", 64'(e.ascii), 64'("-32768"));
    e = model(16'hFFFF, 6, 1'b1, 1'b1);
    chk("pin_m1_ascii", 64'(e.ascii), 64'("    -1"));

    // Reset state.
    tick();
    tick();
    @(negedge clk);
    chk("rst_valid", 64'(a_valid), 64'd0);
    chk("rst_in_ready", 64'(a_ready), 64'd0);
    chk("rst_ndig", 64'(a_ndig), 64'd0);
    chk("rst_ascii", 64'(a_ascii), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", 64'(a_ready), 64'd1);
    tick();

    // Directed values.
    send(16'hFFFF, hs);
    wait_valid(hs, lat);
    chk("latency", 64'(lat), 64'd18);
    chk("d65535_bcd", 64'(a_bcd), 64'h65535);
    chk("d65535_ndig", 64'(a_ndig), 64'd5);
    chk("d65535_ascii", 64'(a_ascii), 64'("65535"));
    chk("dm1_ascii", 64'(c_ascii), 64'("    -1"));
    chk("dm1_neg", 64'(c_neg), 64'd1);
    tick();

    send(16'd0, hs);
    wait_valid(hs, lat);
    chk("d0_blank", 64'(a_ascii), 64'("    0"));
    chk("d0_noblank", 64'(b_ascii), 64'("00000"));
    chk("d0_ndig", 64'(a_ndig), 64'd1);
    tick();

    send(16'h8000, hs);
    wait_valid(hs, lat);
    chk("d8000_bcd", 64'(c_bcd), 64'h032768);
    chk("d8000_neg", 64'(c_neg), 64'd1);
    chk("d8000_ndig", 64'(c_ndig), 64'd5);
    chk("d8000_ascii", 64'(c_ascii), 64'("-32768"));
    chk("d8000_uns", 64'(a_ascii), 64'("32768"));
    tick();

    // Consumer stall with extra input offered.
    ready_mode = 1;
    send(16'd4321, hs);
    wait_valid(hs, lat);
    tick();
    in_valid = 1'b1;
    in_bin   = 16'd999;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      chk("stall_valid", 64'(a_valid), 64'd1);
      chk("stall_in_ready", 64'(a_ready), 64'd0);
      chk("stall_ascii", 64'(a_ascii), 64'(" 4321"));
    end
    tick();
    in_valid   = 1'b0;
    ready_mode = 0;
    repeat (4) tick();

    // Reset in the middle of a conversion.
    send(16'd5555, hs);
    repeat (6) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_valid", 64'(a_valid), 64'd0);
    chk("midrst_ready", 64'(a_ready), 64'd1);
    chk("midrst_bcd", 64'(a_bcd), 64'd0);
    chk("midrst_ascii", 64'(a_ascii), 64'd0);
    tick();
    send(16'd1234, hs);
    wait_valid(hs, lat);
    chk("d1234_ascii", 64'(a_ascii), 64'(" 1234"));
    tick();

    // Back-to-back with the consumer always ready.
    hs_prev = 0;
    for (int i = 0; i < 3; i++) begin
      send(b2b[i], hs);
      if (i > 0) chk("b2b_spacing", 64'(hs - hs_prev), 64'd19);
      hs_prev = hs;
    end
    wait_valid(hs, lat);
    chk("b2b_last", 64'(a_ascii), 64'("10000"));
    tick();

    // Randomized traffic, random backpressure, occasional resets.
    ready_mode = 2;
    for (int k = 0; k < 150; k++) begin
      case ($urandom_range(0, 5))
        0:       v = 16'd0;
        1:       v = 16'hFFFF;
        2:       v = 16'h8000;
        3:       v = 16'h7FFF;
        default: v = 16'($urandom);
      endcase
      send(v, hs);
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 24)) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end else begin
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    ready_mode = 0;
    repeat (40) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
